// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch PC unit.
// The state encoding is kept here so the core and its benches agree on it.
package fetch_pkg;

  localparam int PC_W_DEF    = 32;
  localparam int INSTR_W_DEF = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding instruction-fetch sequencer.
// The incrementer is external: pc_out feeds it and pc_next_in comes back from it.
//
// state | meaning
// REQ   | request at pc is on the memory port, waiting for the memory to accept it
// WAIT  | one request outstanding; kill=1 means its response is discarded
// OUT   | fetched instruction is held for decode until it is accepted
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    pc_out,
  input  logic [PC_W-1:0]    pc_next_in,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [PC_W-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr
);

  fetch_state_t      state;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   req_pc;
  logic              kill;

  // The request port is decoded, gated by reset so nothing leaks out while held.
  assign pc_out         = pc;
  assign imem_addr      = pc;
  assign imem_req_valid = rst_n && (state == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= REQ;
      pc       <= RESET_PC;
      req_pc   <= '0;
      kill     <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else begin
      case (state)
        REQ: begin
          if (imem_req_ready) begin
            req_pc <= pc;
            state  <= WAIT;
          end
          if (redirect_valid) begin
            pc <= redirect_target;
            if (imem_req_ready) kill <= 1'b1;
          end else if (imem_req_ready) begin
            pc <= pc_next_in;
          end
        end

        WAIT: begin
          if (redirect_valid) pc <= redirect_target;
          if (imem_rsp_valid) begin
            if (!kill && !redirect_valid) begin
              if_instr <= imem_rsp_data;
              if_pc    <= req_pc;
              if_valid <= 1'b1;
              state    <= OUT;
            end else begin
              kill  <= 1'b0;
              state <= REQ;
            end
          end else if (redirect_valid) begin
            kill <= 1'b1;
          end
        end

        OUT: begin
          // A redirect squashes the held instruction even if decode takes it now.
          if (redirect_valid) begin
            pc       <= redirect_target;
            if_valid <= 1'b0;
            state    <= REQ;
          end else if (if_ready) begin
            if_valid <= 1'b0;
            state    <= REQ;
          end
        end

        default: begin
          state <= REQ;
          kill  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: stimulus pushes expected requests and
// decode transfers, independent monitors pop and compare them.
module tb_fetch_pc_unit;
  import fetch_pkg::*;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [PC_W-1:0]    pc_out;
  logic [PC_W-1:0]    pc_next_in;
  logic               redirect_valid = 1'b0;
  logic [PC_W-1:0]    redirect_target = '0;
  logic               imem_req_valid;
  logic               imem_req_ready = 1'b0;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_rsp_valid = 1'b0;
  logic [INSTR_W-1:0] imem_rsp_data = '0;
  logic               if_valid;
  logic               if_ready = 1'b1;
  logic [PC_W-1:0]    if_pc;
  logic [INSTR_W-1:0] if_instr;

  fetch_pc_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_out          (pc_out),
    .pc_next_in      (pc_next_in),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr)
  );

  // Stand-in for the external word incrementer.
  assign pc_next_in = pc_out + 32'd1;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } if_exp_t;

  if_exp_t         exp_if_q[$];
  logic [PC_W-1:0] exp_addr_q[$];
  int              if_cyc_q[$];
  int              total = 0;
  int              bad = 0;
  int              cyc = 0;
  int              n_if_hs = 0;
  int              rsp_lat = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Memory model: data word is 0xA5A50000 + address.
  initial begin
    logic            hs;
    logic [PC_W-1:0] a;
    forever begin
      @(negedge clk);
      hs = imem_req_valid && imem_req_ready;
      a  = imem_addr;
      if (hs) begin
        @(posedge clk);
        repeat (rsp_lat - 1) @(posedge clk);
        #1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hA5A5_0000 + a;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && imem_req_valid && imem_req_ready) begin
      if (exp_addr_q.size() == 0) fail_now($sformatf("unexpected_req addr=%08h", imem_addr));
      else check("imem_addr", imem_addr, exp_addr_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if_exp_t e;
    if (rst_n && if_valid && if_ready) begin
      n_if_hs++;
      if_cyc_q.push_back(cyc);
      if (exp_if_q.size() == 0) begin
        fail_now($sformatf("unexpected_if pc=%08h instr=%08h", if_pc, if_instr));
      end else begin
        e = exp_if_q.pop_front();
        check("if_pc", if_pc, e.pc);
        check("if_instr", if_instr, e.instr);
      end
    end
  end

  task automatic push_addr(input logic [PC_W-1:0] a);
    exp_addr_q.push_back(a);
  endtask

  task automatic push_if(input logic [PC_W-1:0] p, input logic [INSTR_W-1:0] d);
    if_exp_t e;
    e.pc = p;
    e.instr = d;
    exp_if_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    if_ready = 1'b1;
    redirect_valid = 1'b0;
    rsp_lat = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_if_valid", 32'(if_valid), 32'h0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, 32'h0);
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    n_if_hs = 0;
    if_cyc_q.delete();
  endtask

  task automatic wait_addr(input logic [PC_W-1:0] a, input int budget);
    bool_loop : begin
      for (int i = 0; i < budget; i++) begin
        @(posedge clk);
        #1;
        if (imem_req_valid && imem_addr == a) disable bool_loop;
      end
      fail_now($sformatf("timeout waiting for request %08h", a));
    end
  endtask

  task automatic wait_if_pc(input logic [PC_W-1:0] p, input int budget);
    pc_loop : begin
      for (int i = 0; i < budget; i++) begin
        @(posedge clk);
        #1;
        if (if_valid && if_pc == p) disable pc_loop;
      end
      fail_now($sformatf("timeout waiting for if_pc %08h", p));
    end
  endtask

  task automatic wait_if_count(input int n, input int budget);
    cnt_loop : begin
      for (int i = 0; i < budget; i++) begin
        @(posedge clk);
        #1;
        if (n_if_hs >= n) disable cnt_loop;
      end
      fail_now($sformatf("timeout waiting for %0d decode transfers", n));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Straight-line fetch at full rate.
    do_reset();
    foreach (exp_addr_q[i]) ;
    push_addr(32'h0); push_addr(32'h1); push_addr(32'h2);
    push_if(32'h0, 32'hA5A5_0000);
    push_if(32'h1, 32'hA5A5_0001);
    push_if(32'h2, 32'hA5A5_0002);
    imem_req_ready = 1'b1;
    rst_n = 1'b1;
    wait_if_count(3, 30);
    imem_req_ready = 1'b0;
    if (if_cyc_q.size() >= 3) begin
      check("gap_0_1", 32'(if_cyc_q[1] - if_cyc_q[0]), 32'd3);
      check("gap_1_2", 32'(if_cyc_q[2] - if_cyc_q[1]), 32'd3);
    end else begin
      fail_now("missing decode transfers in straight-line fetch");
    end

    // Decode back-pressure holds the instruction and blocks new requests.
    do_reset();
    push_addr(32'h0); push_addr(32'h1);
    push_if(32'h0, 32'hA5A5_0000);
    push_if(32'h1, 32'hA5A5_0001);
    imem_req_ready = 1'b1;
    rst_n = 1'b1;
    wait_if_pc(32'h1, 30);
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_if_valid", 32'(if_valid), 32'h1);
      check("stall_if_pc", if_pc, 32'h1);
      check("stall_if_instr", if_instr, 32'hA5A5_0001);
      check("stall_req_valid", 32'(imem_req_valid), 32'h0);
    end
    imem_req_ready = 1'b0;
    if_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_stall_if_valid", 32'(if_valid), 32'h0);
    check("post_stall_req_valid", 32'(imem_req_valid), 32'h1);
    check("post_stall_addr", imem_addr, 32'h2);

    // Redirect while waiting on a slow response for address 2.
    do_reset();
    rsp_lat = 3;
    push_addr(32'h0); push_addr(32'h1); push_addr(32'h2); push_addr(32'h40);
    push_if(32'h0, 32'hA5A5_0000);
    push_if(32'h1, 32'hA5A5_0001);
    push_if(32'h40, 32'hA5A5_0040);
    imem_req_ready = 1'b1;
    rst_n = 1'b1;
    wait_addr(32'h2, 40);
    @(posedge clk);
    #1;
    redirect_target = 32'h40;
    redirect_valid = 1'b1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    check("wait_redirect_pc", pc_out, 32'h40);
    wait_if_count(3, 40);
    imem_req_ready = 1'b0;

    // Redirect coinciding with the handshake for address 3.
    do_reset();
    push_addr(32'h0); push_addr(32'h1); push_addr(32'h2); push_addr(32'h3);
    push_addr(32'h80);
    push_if(32'h0, 32'hA5A5_0000);
    push_if(32'h1, 32'hA5A5_0001);
    push_if(32'h2, 32'hA5A5_0002);
    push_if(32'h80, 32'hA5A5_0080);
    imem_req_ready = 1'b1;
    rst_n = 1'b1;
    wait_addr(32'h3, 40);
    redirect_target = 32'h80;
    redirect_valid = 1'b1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    check("hs_redirect_pc", pc_out, 32'h80);
    check("hs_redirect_req_valid", 32'(imem_req_valid), 32'h0);
    wait_if_count(4, 40);
    imem_req_ready = 1'b0;

    // PC wrap from all-ones to zero.
    do_reset();
    redirect_target = 32'hFFFF_FFFF;
    redirect_valid = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    check("wrap_pc", pc_out, 32'hFFFF_FFFF);
    check("wrap_req_addr", imem_addr, 32'hFFFF_FFFF);
    push_addr(32'hFFFF_FFFF); push_addr(32'h0);
    push_if(32'hFFFF_FFFF, 32'hA5A4_FFFF);
    push_if(32'h0, 32'hA5A5_0000);
    imem_req_ready = 1'b1;
    wait_if_count(2, 30);
    imem_req_ready = 1'b0;

    // Reset while a request is outstanding; its late response must be ignored.
    do_reset();
    rsp_lat = 4;
    push_addr(32'h0);
    imem_req_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    check("midrst_req_valid", 32'(imem_req_valid), 32'h0);
    check("midrst_pc", pc_out, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("stale_if_valid", 32'(if_valid), 32'h0);
      check("stale_pc", pc_out, 32'h0);
      check("stale_req_addr", imem_addr, 32'h0);
    end
    rsp_lat = 1;
    push_addr(32'h0);
    push_if(32'h0, 32'hA5A5_0000);
    imem_req_ready = 1'b1;
    wait_if_count(1, 20);
    imem_req_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("addr_q_left", 32'(exp_addr_q.size()), 32'h0);
    check("if_q_left", 32'(exp_if_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
